// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with destination resolution and load-use stall.
// Optional ID_EX_STALL_CNT_EN adds a saturating count of hazard bubbles on o_stall_cnt.
module id_ex_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 32,
  parameter int NB_REG  = 5
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_halt,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic               i_jump,
  input  logic               i_branch,
  input  logic               i_regDst,
  input  logic               i_mem2Reg,
  input  logic               i_regWrite,
  input  logic               i_memRead,
  input  logic               i_memWrite,
  input  logic               i_sign_flag,
  input  logic               i_immediate,
  input  logic [1:0]         i_aluSrc,
  input  logic [1:0]         i_aluOp,
  input  logic [1:0]         i_width,
  input  logic [5:0]         i_opcode,
  input  logic [5:0]         i_funct,
  input  logic [NB_ADDR-1:0] i_pc,
  input  logic [NB_DATA-1:0] i_rs_data,
  input  logic [NB_DATA-1:0] i_rt_data,
  input  logic [NB_DATA-1:0] i_imm_ext,
  input  logic [NB_REG-1:0]  i_rs,
  input  logic [NB_REG-1:0]  i_rt,
  input  logic [NB_REG-1:0]  i_rd,
  output logic               o_jump,
  output logic               o_branch,
  output logic               o_regDst,
  output logic               o_mem2Reg,
  output logic               o_regWrite,
  output logic               o_memRead,
  output logic               o_memWrite,
  output logic               o_sign_flag,
  output logic               o_immediate,
  output logic [1:0]         o_aluSrc,
  output logic [1:0]         o_aluOp,
  output logic [1:0]         o_width,
  output logic [5:0]         o_funct,
  output logic [NB_ADDR-1:0] o_pc,
  output logic [NB_DATA-1:0] o_rs_data,
  output logic [NB_DATA-1:0] o_rt_data,
  output logic [NB_DATA-1:0] o_imm_ext,
  output logic [NB_REG-1:0]  o_rs,
  output logic [NB_REG-1:0]  o_rt,
  output logic [NB_REG-1:0]  o_dst_reg,
  output logic               o_valid,
  output logic               o_stall,
  output logic [31:0]        o_stall_cnt
);
  logic              rt_use, hazard, bubble;
  logic [NB_REG-1:0] dst;
  assign dst    = (i_opcode == 6'b000011) ? NB_REG'(31) : i_regDst ? i_rd : i_rt;
  assign rt_use = (i_aluSrc == 2'b00) | i_memWrite;
  assign hazard = o_memRead & o_valid & (o_dst_reg != '0) & i_valid &
                  ((o_dst_reg == i_rs) | (rt_use & (o_dst_reg == i_rt)));
  assign o_stall = hazard & ~i_flush;
  // flush, hazard and an empty ID slot all load the same bubble control values
  assign bubble = i_flush | hazard | ~i_valid;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      {o_jump, o_branch, o_regDst, o_mem2Reg, o_regWrite, o_memRead, o_memWrite,
       o_sign_flag, o_immediate} <= '0;
      o_aluSrc  <= '0;
      o_aluOp   <= '0;
      o_width   <= 2'b11;
      o_funct   <= '0;
      o_pc      <= '0;
      o_rs_data <= '0;
      o_rt_data <= '0;
      o_imm_ext <= '0;
      o_rs      <= '0;
      o_rt      <= '0;
      o_dst_reg <= '0;
      o_valid   <= 1'b0;
    end else if (!i_halt) begin
      {o_jump, o_branch, o_regDst, o_mem2Reg, o_regWrite, o_memRead, o_memWrite,
       o_sign_flag, o_immediate} <= bubble ? 9'd0 :
        {i_jump, i_branch, i_regDst, i_mem2Reg, i_regWrite, i_memRead, i_memWrite,
         i_sign_flag, i_immediate};
      o_aluSrc  <= bubble ? 2'b00 : i_aluSrc;
      o_aluOp   <= bubble ? 2'b00 : i_aluOp;
      o_width   <= bubble ? 2'b11 : i_width;
      o_funct   <= i_funct;
      o_pc      <= i_pc;
      o_rs_data <= i_rs_data;
      o_rt_data <= i_rt_data;
      o_imm_ext <= i_imm_ext;
      o_rs      <= i_rs;
      o_rt      <= i_rt;
      o_dst_reg <= bubble ? '0 : dst;
      o_valid   <= ~bubble;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) o_stall_cnt <= '0;
    else if (o_stall && !i_halt && o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + 32'd1;
  end
`else
  assign o_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table, hand-written corner sequences and random stimulus vs a reference model.
module tb_id_ex_stage;
`ifdef ID_EX_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  typedef struct packed {
    logic halt, flush, valid, jump, branch, regDst, mem2Reg, regWrite, memRead, memWrite, sign_flag, immediate;
    logic [1:0] aluSrc, aluOp, width;
    logic [5:0] opcode, funct;
    logic [31:0] pc, rs_data, rt_data, imm;
    logic [4:0] rs, rt, rd;
  } in_t;
  typedef struct packed {
    logic jump, branch, regDst, mem2Reg, regWrite, memRead, memWrite, sign_flag, immediate;
    logic [1:0] aluSrc, aluOp, width;
    logic [5:0] funct;
    logic [31:0] pc, rs_data, rt_data, imm;
    logic [4:0] rs, rt, dst;
    logic valid;
  } ex_t;
  typedef struct {
    in_t in;
    logic stall, valid;
    logic [4:0] dst;
    logic mr;
    int cnt;
  } vec_t;

  logic clk = 0, i_rst = 1;
  in_t cur = '0;
  logic o_jump, o_branch, o_regDst, o_mem2Reg, o_regWrite, o_memRead, o_memWrite, o_sign_flag, o_immediate;
  logic [1:0] o_aluSrc, o_aluOp, o_width;
  logic [5:0] o_funct;
  logic [31:0] o_pc, o_rs_data, o_rt_data, o_imm_ext, o_stall_cnt;
  logic [4:0] o_rs, o_rt, o_dst_reg;
  logic o_valid, o_stall;
  ex_t act, m;
  logic [31:0] mcnt;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .i_rst(i_rst), .i_halt(cur.halt), .i_flush(cur.flush), .i_valid(cur.valid),
    .i_jump(cur.jump), .i_branch(cur.branch), .i_regDst(cur.regDst), .i_mem2Reg(cur.mem2Reg),
    .i_regWrite(cur.regWrite), .i_memRead(cur.memRead), .i_memWrite(cur.memWrite),
    .i_sign_flag(cur.sign_flag), .i_immediate(cur.immediate), .i_aluSrc(cur.aluSrc),
    .i_aluOp(cur.aluOp), .i_width(cur.width), .i_opcode(cur.opcode), .i_funct(cur.funct),
    .i_pc(cur.pc), .i_rs_data(cur.rs_data), .i_rt_data(cur.rt_data), .i_imm_ext(cur.imm),
    .i_rs(cur.rs), .i_rt(cur.rt), .i_rd(cur.rd),
    .o_jump(o_jump), .o_branch(o_branch), .o_regDst(o_regDst), .o_mem2Reg(o_mem2Reg),
    .o_regWrite(o_regWrite), .o_memRead(o_memRead), .o_memWrite(o_memWrite),
    .o_sign_flag(o_sign_flag), .o_immediate(o_immediate), .o_aluSrc(o_aluSrc), .o_aluOp(o_aluOp),
    .o_width(o_width), .o_funct(o_funct), .o_pc(o_pc), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
    .o_imm_ext(o_imm_ext), .o_rs(o_rs), .o_rt(o_rt), .o_dst_reg(o_dst_reg), .o_valid(o_valid),
    .o_stall(o_stall), .o_stall_cnt(o_stall_cnt)
  );

  assign act = {o_jump, o_branch, o_regDst, o_mem2Reg, o_regWrite, o_memRead, o_memWrite, o_sign_flag,
                o_immediate, o_aluSrc, o_aluOp, o_width, o_funct, o_pc, o_rs_data, o_rt_data, o_imm_ext,
                o_rs, o_rt, o_dst_reg, o_valid};

  task automatic chk(string name, logic [255:0] a, logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  function automatic ex_t rst_ex();
    ex_t e = '0;
    e.width = 2'b11;
    return e;
  endfunction

  // EX holds a real load whose nonzero destination the ID instruction reads
  function automatic logic load_use(ex_t e, in_t i);
    logic reads_rt = (i.aluSrc == 2'b00) || i.memWrite;
    return e.valid && e.memRead && e.dst != 0 && i.valid && (e.dst == i.rs || (reads_rt && e.dst == i.rt));
  endfunction

  function automatic ex_t next_ex(ex_t e, in_t i);
    ex_t n = rst_ex();
    if (i.halt) return e;
    n.funct = i.funct; n.pc = i.pc; n.rs_data = i.rs_data; n.rt_data = i.rt_data;
    n.imm = i.imm; n.rs = i.rs; n.rt = i.rt;
    if (i.flush || load_use(e, i) || !i.valid) return n;
    {n.jump, n.branch, n.regDst, n.mem2Reg, n.regWrite, n.memRead, n.memWrite, n.sign_flag, n.immediate} =
      {i.jump, i.branch, i.regDst, i.mem2Reg, i.regWrite, i.memRead, i.memWrite, i.sign_flag, i.immediate};
    n.aluSrc = i.aluSrc; n.aluOp = i.aluOp; n.width = i.width;
    n.dst = i.opcode == 6'd3 ? 5'd31 : i.regDst ? i.rd : i.rt;
    n.valid = 1'b1;
    return n;
  endfunction

  task automatic step(in_t i, output logic st);
    @(negedge clk);
    cur = i;
    #1;
    chk("stall", o_stall, load_use(m, i) && !i.flush);
    st = o_stall;
    @(posedge clk);
    if (CNT_EN && !i.halt && !i.flush && load_use(m, i) && mcnt != 32'hFFFF_FFFF) mcnt++;
    m = next_ex(m, i);
    #1;
    chk("ex_regs", act, m);
    chk("stall_cnt", o_stall_cnt, mcnt);
  endtask

  function automatic in_t lw(logic [4:0] rs, logic [4:0] rt);
    in_t i = '0;
    i.valid = 1; i.memRead = 1; i.regWrite = 1; i.mem2Reg = 1; i.aluSrc = 2'b01; i.width = 2'b11;
    i.opcode = 6'h23; i.rs = rs; i.rt = rt; i.rd = 5'd7; i.pc = 32'h100 + rt; i.imm = 32'h10;
    i.rs_data = 32'hA000 + rs;
    return i;
  endfunction

  function automatic in_t rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    in_t i = '0;
    i.valid = 1; i.regDst = 1; i.regWrite = 1; i.aluOp = 2'b10; i.width = 2'b11; i.funct = 6'h20;
    i.rs = rs; i.rt = rt; i.rd = rd; i.pc = 32'h200 + rd; i.rs_data = 32'h11; i.rt_data = 32'h22;
    return i;
  endfunction

  function automatic in_t addi(logic [4:0] rs, logic [4:0] rt);
    in_t i = '0;
    i.valid = 1; i.regWrite = 1; i.immediate = 1; i.aluSrc = 2'b01; i.width = 2'b11; i.opcode = 6'h08;
    i.rs = rs; i.rt = rt; i.rd = 5'd7; i.imm = 32'h5; i.pc = 32'h300;
    return i;
  endfunction

  function automatic in_t jal();
    in_t i = '0;
    i.valid = 1; i.jump = 1; i.regWrite = 1; i.opcode = 6'd3; i.width = 2'b11; i.pc = 32'h400; i.rd = 5'd3;
    return i;
  endfunction

  function automatic in_t flushed(in_t i);
    in_t r = i;
    r.flush = 1;
    return r;
  endfunction

  function automatic in_t invalid(in_t i);
    in_t r = i;
    r.valid = 0;
    return r;
  endfunction

  function automatic in_t halted(in_t i);
    in_t r = i;
    r.halt = 1;
    return r;
  endfunction

  initial begin
    vec_t tv[16];
    logic st;
    in_t r;
    tv[0]  = '{lw(1, 8), 0, 1, 8, 1, 0};
    tv[1]  = '{rtype(8, 2, 3), 1, 0, 0, 0, 1};
    tv[2]  = '{rtype(8, 2, 3), 0, 1, 3, 0, 1};
    tv[3]  = '{lw(1, 8), 0, 1, 8, 1, 1};
    tv[4]  = '{addi(1, 8), 0, 1, 8, 0, 1};
    tv[5]  = '{lw(1, 0), 0, 1, 0, 1, 1};
    tv[6]  = '{rtype(0, 0, 4), 0, 1, 4, 0, 1};
    tv[7]  = '{lw(1, 9), 0, 1, 9, 1, 1};
    tv[8]  = '{flushed(rtype(1, 9, 5)), 0, 0, 0, 0, 1};
    tv[9]  = '{lw(1, 10), 0, 1, 10, 1, 1};
    tv[10] = '{lw(10, 11), 1, 0, 0, 0, 2};
    tv[11] = '{lw(10, 11), 0, 1, 11, 1, 2};
    tv[12] = '{rtype(11, 0, 12), 1, 0, 0, 0, 3};
    tv[13] = '{rtype(11, 0, 12), 0, 1, 12, 0, 3};
    tv[14] = '{jal(), 0, 1, 31, 0, 3};
    tv[15] = '{invalid(rtype(1, 2, 6)), 0, 0, 0, 0, 3};

    m = rst_ex();
    mcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_regs", act, rst_ex());
    chk("reset_stall", o_stall, 0);
    chk("reset_cnt", o_stall_cnt, 0);
    @(negedge clk);
    i_rst = 0;

    for (int k = 0; k < 16; k++) begin
      step(tv[k].in, st);
      chk($sformatf("vec%0d_stall", k), st, tv[k].stall);
      chk($sformatf("vec%0d_valid", k), o_valid, tv[k].valid);
      chk($sformatf("vec%0d_dst", k), o_dst_reg, tv[k].dst);
      chk($sformatf("vec%0d_memread", k), o_memRead, tv[k].mr);
      chk($sformatf("vec%0d_cnt", k), o_stall_cnt, CNT_EN ? tv[k].cnt : 0);
    end

    // halt over a pending hazard: everything frozen, stall held high
    step(lw(1, 8), st);
    for (int k = 0; k < 3; k++) begin
      step(halted(rtype(8, 2, 3)), st);
      chk("halt_stall", st, 1);
      chk("halt_frozen", {o_valid, o_dst_reg, o_memRead, o_pc}, {1'b1, 5'd8, 1'b1, 32'h108});
      chk("halt_cnt", o_stall_cnt, CNT_EN ? 3 : 0);
    end
    step(rtype(8, 2, 3), st);
    chk("halt_release_bubble", {st, o_valid, o_dst_reg}, {1'b1, 1'b0, 5'd0});
    step(rtype(8, 2, 3), st);
    chk("halt_release_load", {st, o_valid, o_dst_reg}, {1'b0, 1'b1, 5'd3});

    // asynchronous reset in the middle of a stall
    step(lw(1, 8), st);
    @(negedge clk);
    cur = rtype(8, 2, 3);
    #1;
    chk("pre_reset_stall", o_stall, 1);
    #1 i_rst = 1;
    #1;
    chk("async_reset_regs", act, rst_ex());
    chk("async_reset_stall", o_stall, 0);
    chk("async_reset_cnt", o_stall_cnt, 0);
    @(negedge clk);
    i_rst = 0;
    m = rst_ex();
    mcnt = 0;

    for (int k = 0; k < 600; k++) begin
      r = '0;
      r.halt = $urandom_range(9) == 0;
      r.flush = $urandom_range(9) == 0;
      r.valid = $urandom_range(6) != 0;
      {r.jump, r.branch, r.regDst, r.mem2Reg, r.regWrite, r.memRead, r.memWrite, r.sign_flag, r.immediate} = 9'($urandom);
      r.aluSrc = 2'($urandom); r.aluOp = 2'($urandom); r.width = 2'($urandom);
      r.opcode = $urandom_range(3) == 0 ? 6'd3 : 6'($urandom);
      r.funct = 6'($urandom); r.pc = $urandom; r.rs_data = $urandom; r.rt_data = $urandom; r.imm = $urandom;
      r.rs = 5'($urandom_range(3)); r.rt = 5'($urandom_range(3)); r.rd = 5'($urandom_range(3));
      step(r, st);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
